div_ctrl: RTL and testbench

//  Sequencer between the EX stage and the multi-cycle divider (DIV/DIVU/REM/REMU).

---
 rtl/div_ctrl.sv | 102 ++++++++++
 tb/tb_div_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: sequences EX divide ops through a multi-cycle divider, resolves fast cases and arbitrates writeback
module div_ctrl #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_div_valid_i,
  input  logic [2:0]            ex_div_op_i,
  input  logic [DATA_W-1:0]     ex_data1_i,
  input  logic [DATA_W-1:0]     ex_data2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  div_req_o,
  output logic [2:0]            div_op_o,
  output logic [DATA_W-1:0]     div_data1_o,
  output logic [DATA_W-1:0]     div_data2_o,
  output logic [REG_ADDR_W-1:0] div_rd_o,
  input  logic                  div_busy_i,
  input  logic                  div_res_ready_i,
  input  logic [DATA_W-1:0]     div_res_i,
  output logic                  wb_req_o,
  input  logic                  wb_gnt_i,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic                  err_o
);
  typedef enum logic [1:0] {IDLE, RUN, WB, DRAIN} state_t;
  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [DATA_W-1:0] MIN = {1'b1, {(DATA_W-1){1'b0}}};
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0] op_q;
  logic [DATA_W-1:0] d1_q, d2_q, wb_data_q, fast_res;
  logic [REG_ADDR_W-1:0] rd_q;
  logic req_q, err_q, accept, zero_div, ovf, fast, tmo;
  // op[1] selects REM/REMU, op[0] clear means signed
  assign accept   = state_q == IDLE && ex_div_valid_i && !flush_i && !div_busy_i;
  assign zero_div = ex_data2_i == '0;
  assign ovf      = !ex_div_op_i[0] && ex_data1_i == MIN && &ex_data2_i;
  assign fast     = zero_div | ovf;
  assign fast_res = zero_div ? (ex_div_op_i[1] ? ex_data1_i : '1) : (ex_div_op_i[1] ? '0 : MIN);
  assign tmo      = cnt_q == CW'(DIV_TIMEOUT - 1);
  assign div_req_o   = req_q;
  assign div_op_o    = op_q;
  assign div_data1_o = d1_q;
  assign div_data2_o = d2_q;
  assign div_rd_o    = rd_q;
  assign wb_rd_o     = rd_q;
  assign wb_data_o   = wb_data_q;
  assign err_o       = err_q;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  // next state: flush beats result, result beats timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (fast ? WB : RUN) : IDLE;
      RUN:     state_d = flush_i ? (div_res_ready_i ? IDLE : DRAIN) :
                         div_res_ready_i ? WB : tmo ? IDLE : RUN;
      WB:      state_d = (flush_i || wb_gnt_i) ? IDLE : WB;
      default: state_d = (div_res_ready_i || !div_busy_i || tmo) ? IDLE : DRAIN;
    endcase
  end
  // pipeline stall and writeback request
  always_comb begin
    stall_o  = state_q == RUN || (state_q == IDLE && ex_div_valid_i && !flush_i) ||
               (state_q == WB && !wb_gnt_i) || (state_q == DRAIN && ex_div_valid_i);
    wb_req_o = state_q == WB && !flush_i;
  end
  // operand latch, result buffer, start pulse, timeout counter and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      op_q      <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      req_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      req_q <= accept && !fast;
      err_q <= tmo && !div_res_ready_i &&
               ((state_q == RUN && !flush_i) || (state_q == DRAIN && div_busy_i));
      cnt_q <= (state_q == RUN || state_q == DRAIN) ? cnt_q + CW'(1) : '0;
      if (accept) begin
        op_q      <= ex_div_op_i;
        d1_q      <= ex_data1_i;
        d2_q      <= ex_data2_i;
        rd_q      <= ex_rd_i;
        wb_data_q <= fast_res;
      end
      if (state_q == RUN && div_res_ready_i && !flush_i) wb_data_q <= div_res_i;
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: table, directed and random checks of div_ctrl against a behavioural divider and result model
module tb_div_ctrl;
  logic clk = 0, rst;
  logic ex_div_valid_i, flush_i, div_busy_i, div_res_ready_i, wb_gnt_i;
  logic [2:0] ex_div_op_i, div_op_o;
  logic [31:0] ex_data1_i, ex_data2_i, div_data1_o, div_data2_o, div_res_i, wb_data_o;
  logic [4:0] ex_rd_i, div_rd_o, wb_rd_o;
  logic stall_o, div_req_o, wb_req_o, err_o;
  int checks = 0, errors = 0;
  int lat = 8;
  bit hang = 0, div_abort = 0, dbusy = 0;
  int dcnt;
  logic [31:0] dres;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk(clk), .rst(rst), .ex_div_valid_i(ex_div_valid_i), .ex_div_op_i(ex_div_op_i),
    .ex_data1_i(ex_data1_i), .ex_data2_i(ex_data2_i), .ex_rd_i(ex_rd_i), .flush_i(flush_i),
    .stall_o(stall_o), .div_req_o(div_req_o), .div_op_o(div_op_o), .div_data1_o(div_data1_o),
    .div_data2_o(div_data2_o), .div_rd_o(div_rd_o), .div_busy_i(div_busy_i),
    .div_res_ready_i(div_res_ready_i), .div_res_i(div_res_i), .wb_req_o(wb_req_o),
    .wb_gnt_i(wb_gnt_i), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .err_o(err_o)
  );

  // RISC-V M-extension division semantics
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit rem, sgn;
    rem = op[1];
    sgn = !op[0];
    if (b == 0) return rem ? a : 32'hFFFFFFFF;
    if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return rem ? 32'h0 : 32'h80000000;
    if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem ? a % b : a / b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // divider: busy after a start pulse, result pulse after lat more cycles unless hung
  initial begin
    div_busy_i = 0;
    div_res_ready_i = 0;
    div_res_i = 0;
    forever begin
      @(negedge clk);
      div_res_ready_i = 0;
      if (rst || div_abort) dbusy = 0;
      else if (dbusy) begin
        if (dcnt > 0) dcnt--;
        else if (!hang) begin
          div_res_ready_i = 1;
          div_res_i = dres;
          dbusy = 0;
        end
      end else if (div_req_o) begin
        dbusy = 1;
        dcnt = lat;
        dres = ref_res(div_op_o, div_data1_o, div_data2_o);
      end
      div_busy_i = dbusy;
    end
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    ex_div_valid_i = 1;
    ex_div_op_i = op;
    ex_data1_i = a;
    ex_data2_i = b;
    ex_rd_i = rd;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit fast, input int gdly);
    int reqs, cyc;
    bit stall_ok, hold_ok;
    @(negedge clk);
    drive(op, a, b, rd);
    #1 chk("accept_stall", stall_o, 1);
    @(negedge clk);
    ex_div_valid_i = 0;
    #1;
    reqs = 0;
    cyc = 0;
    stall_ok = 1;
    while (!wb_req_o && cyc < 100) begin
      reqs += int'(div_req_o);
      if (!stall_o) stall_ok = 0;
      @(negedge clk);
      #1 cyc++;
    end
    chk("wb_req_seen", wb_req_o, 1);
    chk("div_req_pulses", reqs, fast ? 0 : 1);
    if (fast) chk("fast_latency", cyc, 0);
    chk("run_stall", stall_ok, 1);
    hold_ok = 1;
    repeat (gdly) begin
      if (!wb_req_o || !stall_o || wb_data_o !== exp || wb_rd_o !== rd) hold_ok = 0;
      @(negedge clk);
      #1;
    end
    chk("wb_hold", hold_ok, 1);
    wb_gnt_i = 1;
    #1 chk("gnt_stall_drop", stall_o, 0);
    chk("wb_data", wb_data_o, exp);
    chk("wb_rd", wb_rd_o, rd);
    @(negedge clk);
    wb_gnt_i = 0;
    #1 chk("post_gnt_idle", {wb_req_o, stall_o}, 0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [31:0] a, b;
    logic [4:0] rd;
    logic [31:0] exp;
    bit fast;
    int gdly;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int reqs, cyc, req_cyc;
    bit stall_ok, wbbad;
    logic [2:0] op;
    logic [31:0] a, b;
    tbl[0]  = '{3'b100, 32'd100,        32'd7,          5'd1,  32'd14,         1'b0, 5};
    tbl[1]  = '{3'b110, 32'hFFFFFFF9,   32'd2,          5'd2,  32'hFFFFFFFF,   1'b0, 0};
    tbl[2]  = '{3'b101, 32'hFFFFFFFF,   32'd2,          5'd3,  32'h7FFFFFFF,   1'b0, 1};
    tbl[3]  = '{3'b101, 32'd5,          32'd0,          5'd4,  32'hFFFFFFFF,   1'b1, 0};
    tbl[4]  = '{3'b100, 32'h80000000,   32'hFFFFFFFF,   5'd5,  32'h80000000,   1'b1, 2};
    tbl[5]  = '{3'b110, 32'h80000000,   32'hFFFFFFFF,   5'd6,  32'h0,          1'b1, 0};
    tbl[6]  = '{3'b111, 32'd9,          32'd0,          5'd7,  32'd9,          1'b1, 0};
    tbl[7]  = '{3'b110, 32'd7,          32'd0,          5'd8,  32'd7,          1'b1, 3};
    tbl[8]  = '{3'b100, 32'hFFFFFFEC,   32'd6,          5'd9,  32'hFFFFFFFD,   1'b0, 0};
    tbl[9]  = '{3'b110, 32'hFFFFFFEC,   32'd6,          5'd10, 32'hFFFFFFFE,   1'b0, 0};
    tbl[10] = '{3'b111, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd11, 32'h0,          1'b0, 0};
    tbl[11] = '{3'b101, 32'h80000000,   32'hFFFFFFFF,   5'd31, 32'h0,          1'b0, 0};
    rst = 1;
    ex_div_valid_i = 0; ex_div_op_i = 0; ex_data1_i = 0; ex_data2_i = 0; ex_rd_i = 0;
    flush_i = 0; wb_gnt_i = 0;
    repeat (2) @(negedge clk);
    #1 chk("reset_ctrl", {div_req_o, div_op_o, div_rd_o, wb_req_o, wb_rd_o, err_o, stall_o}, 0);
    chk("reset_data1", div_data1_o, 0);
    chk("reset_data2", div_data2_o, 0);
    chk("reset_wbdata", wb_data_o, 0);
    rst = 0;

    // fixed vectors; the first runs at nominal divider latency
    foreach (tbl[i]) begin
      lat = (i == 0) ? 31 : 8;
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].fast, tbl[i].gdly);
    end

    // flush 10 cycles into RUN while a new DIV waits in EX
    lat = 30;
    @(negedge clk);
    drive(3'b100, 32'd100, 32'd7, 5'd3);
    @(negedge clk);
    ex_div_valid_i = 0;
    #1 chk("flush_first_req", div_req_o, 1);
    repeat (9) @(negedge clk);
    flush_i = 1;
    drive(3'b100, 32'd50, 32'd5, 5'd4);
    #1 chk("flush_run_stall", stall_o, 1);
    @(negedge clk);
    flush_i = 0;
    #1 chk("drain_stall", stall_o, 1);
    chk("drain_no_wb", wb_req_o, 0);
    lat = 6;
    reqs = 0; cyc = 0; req_cyc = 0; stall_ok = 1;
    while (!wb_req_o && cyc < 100) begin
      if (div_req_o) begin
        reqs++;
        req_cyc = cyc;
        ex_div_valid_i = 0;
      end
      if (!stall_o) stall_ok = 0;
      @(negedge clk);
      #1 cyc++;
    end
    chk("drain_one_req", reqs, 1);
    chk("drain_waited", req_cyc >= 15, 1);
    chk("drain_stall_held", stall_ok, 1);
    chk("drain_new_data", wb_data_o, 32'd10);
    chk("drain_new_rd", wb_rd_o, 5'd4);
    wb_gnt_i = 1;
    @(negedge clk);
    wb_gnt_i = 0;

    // flush while waiting for writeback grant
    @(negedge clk);
    drive(3'b111, 32'd9, 32'd0, 5'd7);
    @(negedge clk);
    ex_div_valid_i = 0;
    #1 chk("wbflush_req", wb_req_o, 1);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    #1 chk("wbflush_idle", {wb_req_o, stall_o}, 0);

    // hung divider times out after 40 RUN cycles
    hang = 1;
    lat = 5;
    @(negedge clk);
    drive(3'b100, 32'd100, 32'd7, 5'd9);
    @(negedge clk);
    ex_div_valid_i = 0;
    cyc = 1; wbbad = 0; stall_ok = 1;
    #1;
    while (!err_o && cyc < 100) begin
      if (wb_req_o) wbbad = 1;
      if (!stall_o) stall_ok = 0;
      @(negedge clk);
      #1 cyc++;
    end
    chk("timeout_cycle", cyc, 41);
    chk("timeout_no_wb", {wbbad, wb_req_o}, 0);
    chk("timeout_stall", stall_ok, 1);
    @(negedge clk);
    #1 chk("err_one_cycle", {err_o, stall_o}, 0);
    hang = 0;
    div_abort = 1;
    repeat (2) @(negedge clk);
    div_abort = 0;

    // reset mid-RUN
    lat = 30;
    @(negedge clk);
    drive(3'b101, 32'd1000, 32'd3, 5'd12);
    @(negedge clk);
    ex_div_valid_i = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    #1 chk("midrst_ctrl", {div_req_o, div_op_o, div_rd_o, wb_req_o, wb_rd_o, err_o, stall_o}, 0);
    chk("midrst_data1", div_data1_o, 0);
    chk("midrst_wbdata", wb_data_o, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    lat = 4;
    run_op(3'b101, 32'd1000, 32'd3, 5'd12, 32'd333, 1'b0, 0);

    // random back-to-back ops
    for (int n = 0; n < 30; n++) begin
      op = 3'b100 | 3'($urandom_range(3));
      case ($urandom_range(7))
        0:       begin a = $urandom; b = 0; end
        1:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2:       begin a = $urandom; b = $urandom_range(1, 100); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      lat = $urandom_range(2, 35);
      run_op(op, a, b, 5'($urandom), ref_res(op, a, b),
             b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF), $urandom_range(0, 3));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
